// File: rtl/ias_pkg.sv
// Shared definitions for the IAS command sequencer: opcodes, sequencer state and command layout.
package ias_pkg;

    localparam logic [7:0] OP_NOP      = 8'd0;
    localparam logic [7:0] OP_LOAD     = 8'd1;
    localparam logic [7:0] OP_STORE    = 8'd2;
    localparam logic [7:0] OP_ADD      = 8'd3;
    localparam logic [7:0] OP_STORE_AC = 8'd6;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_ISSUE = 2'd1,
        SEQ_DONE  = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic [7:0] opcode;
        logic [7:0] address;
        logic [7:0] data;
    } cmd_t;

    localparam cmd_t CMD_NOP = '{opcode: OP_NOP, address: 8'd0, data: 8'd0};

    // Commands whose accumulator result is worth capturing after write-back.
    function automatic logic is_capture_op(input logic [7:0] opcode);
        return (opcode == OP_LOAD) || (opcode == OP_ADD);
    endfunction

endpackage

// File: rtl/ias_cmd_fifo.sv
// Synchronous command FIFO with occupancy count; head entry is visible on rdata while not empty.
// Handshake: an entry moves on a rising edge where push && !full (write) or pop && !empty (read).
module ias_cmd_fifo
    import ias_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  cmd_t                   wdata,
    input  logic                   pop,
    output cmd_t                   rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

endmodule

// File: rtl/ias_cmd_sequencer.sv
// Replays queued {opcode, address, data} commands onto the IAS core, each held HOLD_CYCLES cycles.
// Optional accumulator capture after LOAD/ADD is enabled by defining IAS_SEQ_RESULT_CAPTURE_EN.
module ias_cmd_sequencer
    import ias_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [7:0]             cmd_opcode,
    input  logic [7:0]             cmd_address,
    input  logic [7:0]             cmd_data,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [7:0]             ias_opcode,
    output logic [7:0]             ias_address,
    output logic [7:0]             ias_data_in,
    input  logic [7:0]             ias_data_out,
    output logic [7:0]             result,
    output logic                   result_valid,
    output seq_state_t             dbg_state
);

    localparam int HW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    seq_state_t    state_q;
    seq_state_t    state_d;
    cmd_t          head;
    cmd_t          cmd_q;
    cmd_t          push_cmd;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          load_head;
    logic          load_nop;
    logic          hold_last;
    logic [HW-1:0] hold_cnt;

    assign push_cmd = '{opcode: cmd_opcode, address: cmd_address, data: cmd_data};
    assign cmd_ready = !fifo_full;

    ias_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cmd_valid),
        .wdata (push_cmd),
        .pop   (pop),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign hold_last = (state_q == SEQ_ISSUE) && (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SEQ_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The FIFO is sampled before the edge, so a push landing on the last hold edge waits for the next start.
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        load_head = 1'b0;
        load_nop  = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                if (start) begin
                    if (!fifo_empty) begin
                        state_d   = SEQ_ISSUE;
                        pop       = 1'b1;
                        load_head = 1'b1;
                    end else begin
                        state_d = SEQ_DONE;
                    end
                end
            end
            SEQ_ISSUE: begin
                if (hold_last) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        load_head = 1'b1;
                    end else begin
                        load_nop = 1'b1;
                        state_d  = SEQ_DONE;
                    end
                end
            end
            SEQ_DONE: begin
                state_d = SEQ_IDLE;
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        dbg_state = state_q;
        case (state_q)
            SEQ_ISSUE: busy = 1'b1;
            SEQ_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_q    <= CMD_NOP;
            hold_cnt <= '0;
        end else if (load_head) begin
            cmd_q    <= head;
            hold_cnt <= '0;
        end else if (load_nop) begin
            cmd_q    <= CMD_NOP;
            hold_cnt <= '0;
        end else if (state_q == SEQ_ISSUE) begin
            hold_cnt <= hold_cnt + HW'(1);
        end
    end

    assign ias_opcode  = cmd_q.opcode;
    assign ias_address = cmd_q.address;
    assign ias_data_in = cmd_q.data;

`ifdef IAS_SEQ_RESULT_CAPTURE_EN
    logic [7:0] result_q;
    logic       result_valid_q;

    // The core's data_out is sampled in the final hold cycle, after write-back has settled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            result_valid_q <= hold_last && is_capture_op(cmd_q.opcode);
            if (hold_last && is_capture_op(cmd_q.opcode)) begin
                result_q <= ias_data_out;
            end
        end
    end

    assign result       = result_q;
    assign result_valid = result_valid_q;
`else
    logic unused_data_out;

    assign unused_data_out = ^ias_data_out;
    assign result          = '0;
    assign result_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_ias_cmd_sequencer.sv
// Directed bench for ias_cmd_sequencer with a small behavioural IAS core and an expected-command queue.
module tb_ias_cmd_sequencer;
    import ias_pkg::*;

    localparam int DEPTH = 8;
    localparam int HOLD  = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [7:0]    cmd_opcode;
    logic [7:0]    cmd_address;
    logic [7:0]    cmd_data;
    logic          start;
    logic          busy;
    logic          done;
    logic [CW-1:0] fifo_count;
    logic [7:0]    ias_opcode;
    logic [7:0]    ias_address;
    logic [7:0]    ias_data_in;
    logic [7:0]    ias_data_out;
    logic [7:0]    result;
    logic          result_valid;
    seq_state_t    dbg_state;

    logic [23:0] exp_q[$];
    logic [7:0]  res_q[$];
    int          checks;
    int          errors;
    int          valid_seen;
    int          valid_exp;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ias_cmd_sequencer #(
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_opcode   (cmd_opcode),
        .cmd_address  (cmd_address),
        .cmd_data     (cmd_data),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .fifo_count   (fifo_count),
        .ias_opcode   (ias_opcode),
        .ias_address  (ias_address),
        .ias_data_in  (ias_data_in),
        .ias_data_out (ias_data_out),
        .result       (result),
        .result_valid (result_valid),
        .dbg_state    (dbg_state)
    );

    // Behavioural IAS core: commits on its own fourth phase; data_out previews the new AC.
    logic [7:0] mem [256];
    logic [7:0] ac;
    int         phase;

    always_comb begin
        ias_data_out = ac;
        if (ias_opcode == OP_LOAD) ias_data_out = mem[ias_address];
        else if (ias_opcode == OP_ADD) ias_data_out = ac + mem[ias_address];
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ac    <= 8'd0;
            phase <= 0;
            for (int i = 0; i < 256; i++) mem[i] <= 8'd0;
        end else if (busy && !done) begin
            if (phase == HOLD - 1) begin
                phase <= 0;
                case (ias_opcode)
                    OP_STORE:    mem[ias_address] <= ias_data_in;
                    OP_LOAD:     ac <= mem[ias_address];
                    OP_ADD:      ac <= ac + mem[ias_address];
                    OP_STORE_AC: mem[ias_address] <= ac;
                    default:     ac <= ac;
                endcase
            end else begin
                phase <= phase + 1;
            end
        end else begin
            phase <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample_result();
        if (result_valid === 1'b1) begin
            valid_seen++;
            if (res_q.size() > 0) chk("result_value", 32'(result), 32'(res_q.pop_front()));
            else chk("unexpected_result_valid", 32'(result_valid), 32'd0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        sample_result();
    endtask

    task automatic push(input logic [7:0] op, input logic [7:0] addr, input logic [7:0] data);
        cmd_valid   = 1'b1;
        cmd_opcode  = op;
        cmd_address = addr;
        cmd_data    = data;
        tick();
        cmd_valid = 1'b0;
        exp_q.push_back({op, addr, data});
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Walks a replay of n commands cycle by cycle; optionally pushes pcmd on hold edge push_k.
    task automatic run_replay(input int n, input int push_k, input logic [23:0] pcmd);
        for (int k = 0; k < n * HOLD; k++) begin
            if (exp_q.size() == 0) chk("exp_q_underflow", 32'(exp_q.size()), 32'd1);
            else chk($sformatf("ias_cmd_k%0d", k), 32'({ias_opcode, ias_address, ias_data_in}), 32'(exp_q[0]));
            chk($sformatf("busy_k%0d", k), 32'(busy), 32'd1);
            chk($sformatf("done_k%0d", k), 32'(done), 32'd0);
            if (k == push_k) begin
                cmd_valid = 1'b1;
                {cmd_opcode, cmd_address, cmd_data} = pcmd;
                exp_q.push_back(pcmd);
            end
            if ((k % HOLD) == HOLD - 1 && exp_q.size() > 0) void'(exp_q.pop_front());
            tick();
            cmd_valid = 1'b0;
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_in_done", 32'(busy), 32'd1);
        chk("ias_nop_after", 32'({ias_opcode, ias_address, ias_data_in}), 32'd0);
        tick();
        chk("done_cleared", 32'(done), 32'd0);
        chk("busy_cleared", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; valid_seen = 0; valid_exp = 0;
        reset = 1'b0; cmd_valid = 1'b0; start = 1'b0;
        cmd_opcode = '0; cmd_address = '0; cmd_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ias", 32'({ias_opcode, ias_address, ias_data_in}), 32'd0);
        chk("rst_result", 32'({result, result_valid}), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(SEQ_IDLE));
        reset = 1'b1;
        tick();

        // ADD program: mem[1]=25, mem[2]=50, AC=mem[1]+mem[2], mem[3]=AC.
        push(OP_STORE, 8'd1, 8'd25);
        push(OP_STORE, 8'd2, 8'd50);
        push(OP_LOAD, 8'd1, 8'd0);
        push(OP_ADD, 8'd2, 8'd0);
        push(OP_STORE_AC, 8'd3, 8'd0);
        chk("add_fifo_count", 32'(fifo_count), 32'd5);
`ifdef IAS_SEQ_RESULT_CAPTURE_EN
        res_q.push_back(8'd25);
        res_q.push_back(8'd75);
        valid_exp = 2;
`endif
        do_start();
        run_replay(5, -1, 24'd0);
        chk("add_mem3", 32'(mem[3]), 32'd75);
        chk("add_fifo_empty", 32'(fifo_count), 32'd0);
        chk("add_valid_count", 32'(valid_seen), 32'(valid_exp));
`ifdef IAS_SEQ_RESULT_CAPTURE_EN
        chk("add_result_hold", 32'(result), 32'd75);
`else
        chk("add_result_tied", 32'(result), 32'd0);
`endif

        // Start with an empty FIFO goes straight to DONE.
        do_start();
        chk("empty_done", 32'(done), 32'd1);
        chk("empty_busy", 32'(busy), 32'd1);
        chk("empty_ias_op", 32'(ias_opcode), 32'd0);
        tick();
        chk("empty_busy_low", 32'(busy), 32'd0);
        chk("empty_done_low", 32'(done), 32'd0);

        // Second command pushed during hold cycle 1 follows back-to-back.
        push(OP_STORE, 8'd10, 8'h5a);
        do_start();
        run_replay(2, 1, {8'h07, 8'd11, 8'h3c});
        chk("concurrent_fifo_count", 32'(fifo_count), 32'd0);

        // A push on the last hold edge is left for the next start.
        push(OP_STORE, 8'd20, 8'h11);
        do_start();
        run_replay(1, HOLD - 1, {OP_STORE, 8'd21, 8'h22});
        chk("late_push_count", 32'(fifo_count), 32'd1);
        do_start();
        run_replay(1, -1, 24'd0);
        chk("late_push_drained", 32'(fifo_count), 32'd0);
        chk("late_push_mem21", 32'(mem[21]), 32'h22);

        // Fill to DEPTH; a ninth valid is refused.
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("fill_ready_%0d", i), 32'(cmd_ready), 32'd1);
            push(OP_STORE, 8'($urandom_range(32, 255)), 8'($urandom_range(0, 255)));
        end
        chk("full_ready", 32'(cmd_ready), 32'd0);
        chk("full_count", 32'(fifo_count), 32'(DEPTH));
        cmd_valid = 1'b1;
        cmd_opcode = OP_STORE; cmd_address = 8'd99; cmd_data = 8'd99;
        tick();
        cmd_valid = 1'b0;
        chk("ninth_refused", 32'(fifo_count), 32'(DEPTH));

        // Reset in the middle of ISSUE aborts and discards queued commands.
        do_start();
        tick();
        chk("mid_count", 32'(fifo_count), 32'(DEPTH - 1));
        chk("mid_ias", 32'({ias_opcode, ias_address, ias_data_in}), 32'(exp_q[0]));
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_ias", 32'({ias_opcode, ias_address, ias_data_in}), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        tick();
        chk("mid_rst_ias", 32'({ias_opcode, ias_address, ias_data_in}), 32'd0);
        chk("mid_rst_count", 32'(fifo_count), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
        chk("mid_rst_state", 32'(dbg_state), 32'(SEQ_IDLE));
        exp_q.delete();
        reset = 1'b1;
        tick();
        chk("post_rst_count", 32'(fifo_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ias_cmd_sequencer.md
# ias_cmd_sequencer

Command sequencer that sits directly upstream of the `IAS` core and replaces hand-driven stimulus on its `opcode`/`address`/`data_in` inputs. A host pushes {opcode, address, data} commands into an internal FIFO. On `start`, the block replays them to the core back-to-back, holding each for a fixed number of cycles. It also captures the core's `data_out` after LOAD and ADD commands.

## Interface
- `DEPTH`, 8: command FIFO entries; must be a power of two, ≥2.
- `HOLD_CYCLES`, 4: cycles each command is presented to the core (fetch/decode/execute/write-back); must be ≥2.
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: host command valid.
- `cmd_ready` out 1: FIFO not full.
- `cmd_opcode` in 8: command opcode.
- `cmd_address` in 8: command address.
- `cmd_data` in 8: command data.
- `start` in 1: begin replay; ignored while `busy`.
- `busy` out 1: high in ISSUE and DONE.
- `done` out 1: one-cycle pulse at end of replay.
- `fifo_count` out $clog2(DEPTH)+1: entries held.
- `ias_opcode` out 8: drives core `opcode`.
- `ias_address` out 8: drives core `address`.
- `ias_data_in` out 8: drives core `data_in`.
- `ias_data_out` in 8: core `data_out` (AC value).
- `result` out 8: last captured AC value.
- `result_valid` out 1: one-cycle pulse when `result` updates.

## Operation
- Reset (asserted): all outputs 0, except `cmd_ready`=1. FIFO emptied, state IDLE, hold counter 0. Reset asserted mid-replay aborts immediately; queued commands are discarded.
- Push: on a clock edge with `cmd_valid && cmd_ready`. `cmd_ready = (fifo_count != DEPTH)`. A push while full cannot occur.
- States: IDLE, ISSUE, DONE.
- IDLE:
  - `start` with `fifo_count>0` → ISSUE. Head is registered onto `ias_*` and popped; hold counter = 0.
  - `start` with an empty FIFO → DONE directly; no command is issued.
- ISSUE: hold counter increments each cycle. On the edge where counter == `HOLD_CYCLES-1`:
  - If the current opcode is LOAD (1) or ADD (3): `result <= ias_data_out`, `result_valid` pulses next cycle.
  - If the FIFO is non-empty: load and pop the next head, counter = 0, stay in ISSUE.
  - Otherwise: `ias_*` ← 0 (NOP), go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Pushes are allowed during ISSUE. A push and a pop on the same edge leave `fifo_count` unchanged. A command pushed on the final hold edge of the last entry is not seen; replay ends and that command waits for the next `start`.
- Any other opcode (0, 2, 6, …) is forwarded unchanged and never captured.
- FIFO read/write pointers wrap modulo `DEPTH`.

## Timing
- `ias_*` are registered outputs. The first command appears the cycle after the `start` edge.
- Each command is held exactly `HOLD_CYCLES` cycles, with no gap between commands.
- N commands: `busy` lasts N·`HOLD_CYCLES`+1 cycles; `done` rises in the last of these.
- `ias_data_out` is sampled in the last hold cycle of its command.

## Configuration
- `IAS_SEQ_RESULT_CAPTURE_EN`:
  - Defined: result capture as above.
  - Undefined: the capture register and compare logic are omitted; `result` and `result_valid` are tied to 0; sequencing is unchanged.

## Structure
- Shared package `ias_pkg`:
  - Opcode constants `OP_NOP=0`, `OP_LOAD=1`, `OP_STORE=2`, `OP_ADD=3`, `OP_STORE_AC=6`.
  - Sequencer state enum.
  - 24-bit command struct.
- Sub-module `ias_cmd_fifo`: synchronous FIFO with count, full and empty outputs. The sequencer FSM, hold counter and capture logic live in the top module.

## Test plan
- Reset: drive `reset`=0 mid-ISSUE with 3 queued → next cycle all `ias_*`=0, `fifo_count`=0, `busy`=0, `cmd_ready`=1.
- Fill: push 8 commands → `cmd_ready`=0 after 8th, `fifo_count`=8. A 9th `cmd_valid` is not accepted.
- ADD program against the IAS model:
  - Push STORE 1/25, STORE 2/50, LOAD 1, ADD 2, STORE_AC 3, then `start`.
  - Required: each command held 4 cycles; `result`=25 after LOAD; `result`=75 after ADD; `mem[3]`=75; `done` in cycle 21 after start.
- Empty start: `start` with FIFO empty → `done` next cycle, `ias_opcode` stays 0, `busy` high 1 cycle.
- Concurrent push: push 1 command, `start`, push a 2nd during hold cycle 1 → both issued back-to-back, `fifo_count` returns to 0.
- Macro undefined: rerun the ADD program → identical `ias_*` trace, `result_valid` never asserted.
